// File: rtl/fb_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg : framebuffer geometry, types and the y*160+x address helper.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fb_pkg;

  localparam int FB_W       = 160;
  localparam int FB_H       = 120;
  localparam int ACT_W      = 640;
  localparam int ACT_H      = 480;
  localparam int SCALE_LOG2 = 2;
  localparam int FB_ADDR_W  = 15;

  typedef logic [11:0]          pixel_t;
  typedef logic [FB_ADDR_W-1:0] fb_addr_t;

  function automatic fb_addr_t fb_addr(input logic [7:0] y, input logic [7:0] x);
    return (fb_addr_t'(y) << 7) + (fb_addr_t'(y) << 5) + fb_addr_t'(x);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fb_scan_addr.sv
// ---------------------------------------------------------------------------
// fb_scan_addr : display-slot detection and address of the next 4-pixel group.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fb_scan_addr
  import fb_pkg::*;
(
  input  logic       de_i,
  input  logic [9:0] row_i,
  input  logic [9:0] col_i,
  output logic       slot_o,
  output fb_addr_t   addr_o
);

  logic [9:0] row_nxt;
  logic [9:0] row_grp;
  logic [9:0] row_nxt_grp;
  logic [9:0] col_grp;
  logic       unused_bits;

  assign row_nxt     = row_i + 10'd1;
  assign row_grp     = row_i >> SCALE_LOG2;
  assign row_nxt_grp = row_nxt >> SCALE_LOG2;
  assign col_grp     = col_i >> SCALE_LOG2;
  assign unused_bits = ^{row_grp[9:8], row_nxt_grp[9:8], col_grp[9:8]};

  assign slot_o = de_i && (col_i[SCALE_LOG2-1:0] == 2'd2);

  // The slot at column 638 prefetches group 0 of the following line.
  always_comb begin
    addr_o = '0;
    if (col_i < 10'(ACT_W - 2)) begin
      addr_o = fb_addr(row_grp[7:0], col_grp[7:0] + 8'd1);
    end else if (row_i < 10'(ACT_H - 1)) begin
      addr_o = fb_addr(row_nxt_grp[7:0], 8'd0);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fb_arbiter.sv
// ---------------------------------------------------------------------------
// fb_arbiter : shares a single-port framebuffer RAM between scanout and a writer.
// Optional FB_READBACK_EN adds buffered reads through the writer port.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fb_arbiter
  import fb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       de,
  input  logic [9:0] row,
  input  logic [9:0] col,
  output pixel_t     rgb,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_x,
  input  logic [6:0] wr_y,
  input  pixel_t     wr_data,
`ifdef FB_READBACK_EN
  input  logic       wr_rd,
  output pixel_t     rd_data,
  output logic       rd_valid,
`endif
  output logic [7:0] drop_cnt,
  output fb_addr_t   ram_addr,
  output logic       ram_we,
  output pixel_t     ram_wdata,
  input  pixel_t     ram_rdata
);

  logic     slot;
  fb_addr_t scan_addr;

  fb_scan_addr u_scan (
    .de_i   (de),
    .row_i  (row),
    .col_i  (col),
    .slot_o (slot),
    .addr_o (scan_addr)
  );

  logic       buf_full_q;
  logic       buf_full_d;
  fb_addr_t   buf_addr_q;
  pixel_t     buf_data_q;
  pixel_t     pixel_q;
  logic       fetch_q;
  fb_addr_t   ram_addr_q;
  logic [7:0] drop_q;
  logic       accept;
  logic       oor;
  logic       commit;
  logic       buf_rd;

  assign oor      = (wr_x >= 8'(FB_W)) || (wr_y >= 7'(FB_H));
  assign commit   = buf_full_q && !slot;
  assign wr_ready = !buf_full_q || commit;
  assign accept   = wr_valid && wr_ready;

  always_comb begin
    buf_full_d = buf_full_q;
    if (commit) buf_full_d = 1'b0;
    if (accept && !oor) buf_full_d = 1'b1;
  end

  always_comb begin
    ram_addr = ram_addr_q;
    if (reset) begin
      ram_addr = '0;
    end else if (slot) begin
      ram_addr = scan_addr;
    end else if (commit) begin
      ram_addr = buf_addr_q;
    end
  end

  assign ram_we    = commit && !buf_rd;
  assign ram_wdata = buf_data_q;
  assign rgb       = pixel_q;
  assign drop_cnt  = drop_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_full_q <= 1'b0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
      pixel_q    <= '0;
      fetch_q    <= 1'b0;
      ram_addr_q <= '0;
      drop_q     <= '0;
    end else begin
      buf_full_q <= buf_full_d;
      fetch_q    <= slot;
      ram_addr_q <= ram_addr;
      if (fetch_q) pixel_q <= ram_rdata;
      if (accept) begin
        buf_addr_q <= fb_addr({1'b0, wr_y}, wr_x);
        buf_data_q <= wr_data;
      end
      if (accept && oor && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
    end
  end

`ifdef FB_READBACK_EN
  logic buf_rd_q;
  logic rd_pend_q;
  logic rd_oor_q;

  assign buf_rd   = buf_rd_q;
  assign rd_valid = rd_pend_q || rd_oor_q;
  assign rd_data  = rd_pend_q ? ram_rdata : '0;

  // An out-of-range read that collides with a real read result waits one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_rd_q  <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_oor_q  <= 1'b0;
    end else begin
      if (accept) buf_rd_q <= wr_rd;
      rd_pend_q <= commit && buf_rd_q;
      rd_oor_q  <= (accept && oor && wr_rd) || (rd_oor_q && rd_pend_q);
    end
  end
`else
  assign buf_rd = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fb_arbiter : randomized scoreboard bench for fb_arbiter.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fb_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        de = 1'b0;
  logic [9:0]  row = '0;
  logic [9:0]  col = '0;
  logic [11:0] rgb;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [7:0]  wr_x = '0;
  logic [6:0]  wr_y = '0;
  logic [11:0] wr_data = '0;
  logic [7:0]  drop_cnt;
  logic [14:0] ram_addr;
  logic        ram_we;
  logic [11:0] ram_wdata;
  logic [11:0] ram_rdata = '0;

  fb_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .de        (de),
    .row       (row),
    .col       (col),
    .rgb       (rgb),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_data   (wr_data),
    .drop_cnt  (drop_cnt),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  function automatic int pat(input int a);
    return (a * 37 + 5) % 4096;
  endfunction

  function automatic int scan_exp(input int r, input int c);
    if (c < 638) return (r / 4) * 160 + c / 4 + 1;
    if (r < 479) return ((r + 1) / 4) * 160;
    return 0;
  endfunction

  // Behavioural RAM: unwritten locations hold a known pattern.
  bit          wv [0:19199];
  logic [11:0] wm [0:19199];
  always @(posedge clk) begin
    if (ram_we) begin
      wv[ram_addr] <= 1'b1;
      wm[ram_addr] <= ram_wdata;
    end
    ram_rdata <= wv[ram_addr] ? wm[ram_addr] : 12'(pat(int'(ram_addr)));
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  typedef struct {
    int acc;
    int addr;
    int data;
  } wr_t;

  wr_t q[$];
  int  rgbq[$];
  int  exp_drop = 0;
  bit  mon_en = 1'b0;
  bit  acc_f = 1'b0;
  int  acc_x, acc_y, acc_d;

  // Monitor: compares every DUT output against the expectations queued by the driver.
  bit m_slot, m_we, m_ready;
  wr_t m_it;
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      m_slot = de && (col[1:0] == 2'd2);
      if (de) begin
        if (rgbq.size() == 0) chk("rgb_queue", 0, 1);
        else begin
          int e;
          e = rgbq.pop_front();
          if (e >= 0) chk("rgb", int'(rgb), e);
        end
      end
      if (m_slot) chk("slot_addr", int'(ram_addr), scan_exp(int'(row), int'(col)));
      chk("drop_cnt", int'(drop_cnt), exp_drop);
      m_we = 1'b0;
      if (q.size() > 0) begin
        if (q[0].acc == cyc && !m_slot) m_we = 1'b1;
        else if (q[0].acc < cyc) m_we = 1'b1;
      end
      m_ready = (q.size() == 0) || !m_slot;
      chk("wr_ready", int'(wr_ready), int'(m_ready));
      chk("ram_we", int'(ram_we), int'(m_we));
      if (m_we) begin
        m_it = q.pop_front();
        if (ram_we) begin
          chk("commit_addr", int'(ram_addr), m_it.addr);
          chk("commit_data", int'(ram_wdata), m_it.data);
        end
      end
    end
  end

  task automatic step(input bit d, input int r, input int c, input bit v,
                      input int x, input int y, input int dat, input int e);
    @(posedge clk);
    #1;
    if (acc_f) begin
      if (acc_x >= 160 || acc_y >= 120) exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
      else q.push_back('{cyc, acc_y * 160 + acc_x, acc_d});
      acc_f = 1'b0;
    end
    de       = d;
    row      = 10'(r);
    col      = 10'(c);
    wr_valid = v;
    wr_x     = 8'(x);
    wr_y     = 7'(y);
    wr_data  = 12'(dat);
    if (d) rgbq.push_back(e);
    @(negedge clk);
    if (wr_valid && wr_ready) begin
      acc_f = 1'b1;
      acc_x = x;
      acc_y = y;
      acc_d = dat;
    end
  endtask

  task automatic rnd_step(input bit d, input int r, input int c, input int e);
    int y;
    y = ($urandom % 8 == 0) ? int'($urandom_range(120, 127)) : int'($urandom_range(3, 118));
    step(d, r, c, bit'($urandom % 2), int'($urandom_range(0, 199)), y, int'($urandom % 4096), e);
  endtask

  int rows[16] = '{476, 477, 478, 479, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11};

  initial begin
    #1 reset = 1'b1;
    #1;
    chk("rst_rgb", int'(rgb), 0);
    chk("rst_ready", int'(wr_ready), 1);
    chk("rst_we", int'(ram_we), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    chk("rst_addr", int'(ram_addr), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    mon_en = 1'b1;

    // Scanout across the frame wrap with random writes to rows never shown.
    for (int li = 0; li < 16; li++) begin
      for (int c = 0; c < 640; c++) begin
        int e;
        e = (li == 0 && c < 4) ? 0 : pat((rows[li] / 4) * 160 + c / 4);
        rnd_step(1'b1, rows[li], c, e);
      end
      for (int b = 0; b < 20; b++) rnd_step(1'b0, 0, 0, -1);
    end
    repeat (3) step(1'b0, 0, 0, 1'b0, 0, 0, 0, -1);

    // Plain write during blanking commits the very next cycle.
    step(1'b0, 0, 0, 1'b1, 5, 3, 12'hF00, -1);
    step(1'b0, 0, 0, 1'b0, 0, 0, 0, -1);
    chk("dir_we", int'(ram_we), 1);
    chk("dir_addr", int'(ram_addr), 485);
    chk("dir_data", int'(ram_wdata), 12'hF00);

    // Write whose commit collides with a display slot.
    step(1'b1, 10, 1, 1'b1, 7, 4, 12'h0A5, -1);
    step(1'b1, 10, 2, 1'b0, 0, 0, 0, -1);
    chk("dir_slot_addr", int'(ram_addr), 321);
    chk("dir_slot_we", int'(ram_we), 0);
    chk("dir_slot_ready", int'(wr_ready), 0);
    step(1'b1, 10, 3, 1'b0, 0, 0, 0, -1);
    chk("dir_defer_we", int'(ram_we), 1);
    chk("dir_defer_addr", int'(ram_addr), 647);
    for (int c = 4; c < 8; c++) step(1'b1, 10, c, 1'b0, 0, 0, 0, pat(321));
    step(1'b0, 0, 0, 1'b0, 0, 0, 0, -1);

    // Out-of-range flood saturates the drop counter.
    for (int i = 0; i < 300; i++)
      step(1'b0, 0, 0, 1'b1, int'($urandom_range(160, 255)), int'($urandom % 128), int'($urandom % 4096), -1);
    step(1'b0, 0, 0, 1'b0, 0, 0, 0, -1);
    step(1'b0, 0, 0, 1'b0, 0, 0, 0, -1);
    chk("drop_sat", int'(drop_cnt), 255);

    // Reset lands while a buffered write is being committed.
    step(1'b1, 20, 9, 1'b1, 9, 9, 12'h123, -1);
    @(posedge clk);
    #1;
    acc_f    = 1'b0;
    wr_valid = 1'b0;
    de       = 1'b1;
    row      = 10'd20;
    col      = 10'd10;
    rgbq.push_back(-1);
    chk("pre_rst_we", int'(ram_we), 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_rgb", int'(rgb), 0);
    chk("mid_rst_ready", int'(wr_ready), 1);
    chk("mid_rst_we", int'(ram_we), 0);
    chk("mid_rst_drop", int'(drop_cnt), 0);
    q.delete();
    rgbq.delete();
    exp_drop = 0;
    de = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) step(1'b0, 0, 0, 1'b0, 0, 0, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
- Shares one single-port synchronous framebuffer RAM between two users: display scanout, which reads the pixel to show, and a writer such as game or draw logic, which updates pixels.
- The framebuffer is 160x120 at 12-bit colour, and each stored pixel is shown as a 4x4 block on the 640x480 active area.
- The block sits between the display timing generator (supplies row, col, de; consumes rgb) and the framebuffer RAM.
- Display fetch always has priority; writes use every remaining RAM cycle.

Parameters:
- FB_W, 160, framebuffer width in pixels.
- FB_H, 120, framebuffer height in pixels.
- ACT_H, 480, active display lines.
- SCALE_LOG2, 2, log2 of the display-to-framebuffer pixel ratio; fixed at 2.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- de  in  1  active-video flag from the timing generator.
- row  in  10  active row, 0..479, valid when de=1.
- col  in  10  active column, 0..639, valid when de=1.
- rgb  out  12  pixel colour to the timing generator's rgb input.
- wr_valid  in  1  writer request.
- wr_ready  out  1  writer may hand over a request.
- wr_x  in  8  framebuffer x.
- wr_y  in  7  framebuffer y.
- wr_data  in  12  pixel colour to write.
- drop_cnt  out  8  saturating count of out-of-range writes.
- ram_addr  out  15  RAM address, captured by the RAM at the clock edge.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  12  RAM write data.
- ram_rdata  in  12  RAM read data, valid the cycle after the address is presented.

Behaviour:
- Reset values: rgb=0, wr_ready=1, drop_cnt=0, ram_we=0, ram_addr=0, write buffer empty. Reset is asynchronous and may assert mid-operation; a buffered write is discarded and ram_we drops immediately.
- Display slot is any cycle with de=1 and col[1:0]==2.
- In a display slot, ram_we=0 and ram_addr is the next group's address:
  - col<638: addr = (row>>2)*160 + (col>>2) + 1.
  - col==638, row<479: addr = ((row+1)>>2)*160.
  - col==638, row==479: addr = 0 (wraps to the top of the frame).
- Pixel register: in the cycle after a display slot, pixel_q <= ram_rdata at the clock edge. rgb = pixel_q at all times.
  - pixel_q holds through blanking, so pixels 0..3 of each line were fetched at col 638 of the previous line.
  - Latency is 2 cycles from the display slot to rgb valid; each fetched value is shown for 4 columns.
- After reset, the first 4 pixels of the first frame show 0.
- Address arithmetic: y*160+x computed as (y<<7)+(y<<5)+x in 15 bits; maximum 19199.
- Write buffer (1 entry, valid/ready):
  - Accept when wr_valid && wr_ready; x, y and data are captured.
  - wr_ready = !buf_full || commit_now.
  - An accepted request never commits in the same cycle it is accepted.
- Commit:
  - Occurs in any cycle where the buffer is full and the current cycle is not a display slot: ram_we=1, ram_addr=buffered address, ram_wdata=buffered data.
  - If a display slot coincides, the commit waits; ram_wdata and the buffer hold.
  - The worst-case wait is 1 cycle, so sustained write throughput during active video is at least 3 per 4 cycles.
- Out-of-range requests (x>=160 or y>=120) are accepted and counted, but never cause ram_we.
  - On acceptance: drop_cnt increments and saturates at 255.
  - The buffer stays empty and ram_we stays 0.
- Outside display slots with no commit: ram_we=0, ram_addr holds its last value.

Optional Feature:
- Macro: FB_READBACK_EN.
- When defined:
  - Adds inputs wr_rd (1 bit, captured with the request) and outputs rd_data (12 bits) and rd_valid (1 bit).
  - A buffered request with wr_rd=1 commits as a read (ram_we=0, same slot rules).
  - The cycle after the read commits, rd_valid=1 and rd_data=ram_rdata, for exactly one cycle.
  - Out-of-range reads return rd_valid=1 with rd_data=0 and increment drop_cnt.
  - rd_valid and rd_data reset to 0.
- When absent: those ports do not exist and every request is a write.

Decomposition:
- Package fb_pkg:
  - FB_W, FB_H, FB_ADDR_W=15, typedef pixel_t (logic [11:0]), typedef fb_addr_t.
  - Function fb_addr(y,x) implementing the shift-add.
- Sub-module fb_scan_addr: combinational display-slot detection and next-group address (row/col wrap rules above), instantiated once.

Test Plan:
- Reset asserted mid-frame with a full buffer -> rgb=0, wr_ready=1, ram_we=0, drop_cnt=0 immediately, before any clock edge.
- de=1, row=10, col=2 -> ram_addr=321, ram_we=0; next cycle ram_rdata=0xABC -> rgb=0xABC from the following cycle, held 4 cycles.
- de=1, col=638, row=20 -> ram_addr=800; col=638, row=479 -> ram_addr=0.
- de=0: x=5, y=3, data=0xF00 accepted -> next cycle ram_we=1, ram_addr=485, ram_wdata=0xF00.
- Buffered write whose commit cycle is de=1, col=2 -> ram_we=0 that cycle, wr_ready=0; commits at col=3.
- 300 writes with x=160 -> no ram_we ever; drop_cnt reads 255. With FB_READBACK_EN: read at (5,3) after writing 0xF00 -> rd_valid=1, rd_data=0xF00.
